// File: rtl/spi_flash_read_ctrl.sv
// W25Q16 READ DATA (0x03) controller: sends the command and a 24-bit address over SPI mode 0, then
// streams READ_LEN bytes out on a valid/ready port, holding SCK low whenever the downstream stalls.
module spi_flash_read_ctrl #(
  parameter int CLK_HALF = 2,
  parameter int READ_LEN = 256,
  parameter int CS_GAP   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] start_addr,
  input  logic        spi_miso,
  output logic        spi_clk,
  output logic        cs,
  output logic        spi_mosi,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        busy,
  output logic        done
);

  localparam int HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int BW = $clog2(READ_LEN + 1);
  localparam logic [HW-1:0] HMAX = HW'(CLK_HALF - 1);
  localparam logic [GW-1:0] GMAX = GW'(CS_GAP - 1);
  localparam logic [BW-1:0] LAST = BW'(READ_LEN - 1);

  if (READ_LEN < 1) begin : g_bad_len
    $fatal(1, "spi_flash_read_ctrl: READ_LEN must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, SETUP, CMD, ADDR, DATA, GAP, FIN} state_t;

  state_t          state, state_nxt;
  logic [HW-1:0]   hcnt;
  logic [GW-1:0]   gcnt;
  logic [BW-1:0]   byte_cnt;
  logic [4:0]      bcnt;
  logic            rise_q;
  logic            full;
  logic [31:0]     hdr;
  logic [7:0]      sh;

  logic run, stall, tick, rise, fall, gcnt_end, last_byte, drained;
  logic sample, byte_done, load;

  always_comb begin
    run       = (state == CMD) || (state == ADDR) || (state == DATA);
    // Freeze SCK low before a new byte while a finished byte still cannot reach rd_data.
    stall     = (state == DATA) && (bcnt == 5'd0) && !spi_clk && full && rd_valid && !rd_ready;
    tick      = run && !stall && (hcnt == HMAX);
    rise      = tick && !spi_clk;
    fall      = tick && spi_clk;
    gcnt_end  = (gcnt == GMAX);
    last_byte = (byte_cnt == LAST);
    drained   = !full && !rd_valid;
    // MISO is taken one clk after the SCK rising edge, mid high phase.
    sample    = rise_q && (state == DATA);
    byte_done = sample && (bcnt == 5'd7);
    load      = full && (!rd_valid || rd_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE:  begin
        busy = 1'b0;
        if (start) state_nxt = SETUP;
      end
      SETUP: if (gcnt_end) state_nxt = CMD;
      CMD:   if (fall && bcnt == 5'd7) state_nxt = ADDR;
      ADDR:  if (fall && bcnt == 5'd31) state_nxt = DATA;
      DATA:  if (fall && bcnt == 5'd7 && last_byte) state_nxt = GAP;
      GAP:   if (cs && drained) state_nxt = FIN;
      FIN:   begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt     <= '0;
      spi_clk  <= 1'b0;
      rise_q   <= 1'b0;
      bcnt     <= '0;
      byte_cnt <= '0;
      gcnt     <= '0;
      cs       <= 1'b1;
      spi_mosi <= 1'b0;
    end else begin
      rise_q <= rise;

      if (!run) begin
        hcnt    <= '0;
        spi_clk <= 1'b0;
      end else if (tick) begin
        hcnt    <= '0;
        spi_clk <= !spi_clk;
      end else if (!stall) begin
        hcnt <= hcnt + 1'b1;
      end

      if (state == IDLE) begin
        bcnt     <= '0;
        byte_cnt <= '0;
      end else if (fall) begin
        if ((state == ADDR && bcnt == 5'd31) || (state == DATA && bcnt == 5'd7)) bcnt <= '0;
        else                                                                     bcnt <= bcnt + 5'd1;
        if (state == DATA && bcnt == 5'd7) byte_cnt <= byte_cnt + 1'b1;
      end

      if (state == SETUP || (state == GAP && !cs)) gcnt <= gcnt_end ? '0 : gcnt + 1'b1;
      else                                        gcnt <= '0;

      if (state == IDLE && start)              cs <= 1'b0;
      else if (state == GAP && !cs && gcnt_end) cs <= 1'b1;

      if (state == SETUP)                             spi_mosi <= hdr[31];
      else if (fall && (state == CMD || state == ADDR)) spi_mosi <= (state == ADDR && bcnt == 5'd31) ? 1'b0 : hdr[30];
      else if (state == IDLE)                          spi_mosi <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full     <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (byte_done) full <= 1'b1;
      else if (load) full <= 1'b0;

      if (load) begin
        rd_data  <= sh;
        rd_valid <= 1'b1;
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
    end
  end

  // Header and receive shift registers carry data only; control qualifies every use.
  always_ff @(posedge clk) begin
    if (state == IDLE && start)                       hdr <= {8'h03, start_addr};
    else if (fall && (state == CMD || state == ADDR)) hdr <= {hdr[30:0], 1'b0};

    if (sample) sh <= {sh[6:0], spi_miso};
  end

endmodule
